// File: rtl/mips_cache_data_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cache_data_if
//  Description : CPU data port, write-buffer push/control and Avalon read
//                signals of the data cache, bundled as one interface.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_cache_data_if;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;

    logic        wb_write_en;
    logic [31:0] wb_addr;
    logic [31:0] wb_writedata;
    logic [3:0]  wb_byteenable;
    logic        wb_full;
    logic        wb_empty;
    logic        wb_active;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    logic [1:0]  state_out;

    // Cache side
    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        output cpu_waitrequest, cpu_readdata,
        output wb_write_en, wb_addr, wb_writedata, wb_byteenable, wb_active,
        input  wb_full, wb_empty,
        output mem_address, mem_read,
        input  mem_waitrequest, mem_readdata,
        output state_out
    );

    // CPU / write buffer / memory side
    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        input  cpu_waitrequest, cpu_readdata,
        input  wb_write_en, wb_addr, wb_writedata, wb_byteenable, wb_active,
        output wb_full, wb_empty,
        input  mem_address, mem_read,
        output mem_waitrequest, mem_readdata,
        input  state_out
    );
endinterface
`default_nettype wire

// File: rtl/mips_cache_data.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cache_data
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                with one-word lines; read misses fetch via Avalon.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cache_data #(
    parameter int INDEX_BITS = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mips_cache_data_if.slave    bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FETCH = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [LINES];
    logic [31:0]         r_resp;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [31:0]           w_line;
    logic [31:0]           w_merged;
    logic                  w_line_wr;
    logic                  w_fill;
    logic                  w_waitrequest;
    logic                  w_wb_write_en;
    logic                  w_wb_active;
    logic                  w_mem_read;
    logic                  w_unused_addr_lsbs;

    assign w_index = bus.cpu_address[2 +: INDEX_BITS];
    assign w_tag   = bus.cpu_address[31 -: TAG_BITS];
    assign w_line  = r_data[w_index];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_unused_addr_lsbs = ^bus.cpu_address[1:0];

    always_comb begin
        w_merged = w_line;
        for (int b = 0; b < 4; b++) begin
            if (bus.cpu_byteenable[b]) begin
                w_merged[8*b +: 8] = bus.cpu_writedata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_waitrequest = 1'b0;
        w_wb_write_en = 1'b0;
        w_wb_active   = 1'b1;
        w_mem_read    = 1'b0;
        w_line_wr     = 1'b0;
        w_fill        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A write takes priority over a simultaneous read
                if (bus.cpu_write) begin
                    if (bus.wb_full) begin
                        w_waitrequest = 1'b1;
                    end else begin
                        w_wb_write_en = 1'b1;
                        w_line_wr     = w_hit;
                    end
                end else if (bus.cpu_read && !w_hit) begin
                    w_waitrequest = 1'b1;
                    w_next        = bus.wb_empty ? S_FETCH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_waitrequest = 1'b1;
                if (bus.wb_empty) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Write buffer is paused while the cache owns the read port
                w_waitrequest = 1'b1;
                w_wb_active   = 1'b0;
                w_mem_read    = 1'b1;
                if (!bus.mem_waitrequest) begin
                    w_fill = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_next;
            if (w_fill) begin
                r_valid[w_index] <= 1'b1;
                r_resp           <= bus.mem_readdata;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_line_wr) begin
                r_data[w_index] <= w_merged;
            end
            if (w_fill) begin
                r_data[w_index] <= bus.mem_readdata;
                r_tag[w_index]  <= w_tag;
            end
        end
    end

    assign bus.cpu_waitrequest = w_waitrequest;
    assign bus.cpu_readdata    = (r_state == S_RESP) ? r_resp : w_line;
    assign bus.wb_write_en     = w_wb_write_en;
    assign bus.wb_addr         = {bus.cpu_address[31:2], 2'b00};
    assign bus.wb_writedata    = bus.cpu_writedata;
    assign bus.wb_byteenable   = bus.cpu_byteenable;
    assign bus.wb_active       = w_wb_active;
    assign bus.mem_address     = {bus.cpu_address[31:2], 2'b00};
    assign bus.mem_read        = w_mem_read;
    assign bus.state_out       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_cache_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cache_data
//  Description : Directed scoreboard bench for mips_cache_data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cache_data;
    logic clk;
    logic rst;
    mips_cache_data_if bus();

    mips_cache_data #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_t;

    logic [31:0] exp_rd [$];
    wb_t         exp_wb [$];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted read response and every push is scored
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cpu_read && !bus.cpu_write && !bus.cpu_waitrequest) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read_resp", bus.cpu_readdata, 32'hxxxx_xxxx);
                end else begin
                    chk("read_data", bus.cpu_readdata, exp_rd.pop_front());
                end
            end
            if (bus.wb_write_en) begin
                if (exp_wb.size() == 0) begin
                    chk("unexpected_wb_push", bus.wb_addr, 32'hxxxx_xxxx);
                end else begin
                    wb_t e;
                    e = exp_wb.pop_front();
                    chk("wb_addr", bus.wb_addr, e.addr);
                    chk("wb_data", bus.wb_writedata, e.data);
                    chk("wb_be", {28'd0, bus.wb_byteenable}, {28'd0, e.be});
                end
            end
        end
    end

    task automatic fetch_phase(input logic [31:0] a, input logic [31:0] d, input int waits);
        bus.mem_readdata = d;
        for (int i = 0; i <= waits; i++) begin
            bus.mem_waitrequest = (i == waits) ? 1'b0 : 1'b1;
            #1;
            chk("fetch_state", {30'd0, bus.state_out}, 32'd2);
            chk("fetch_wb_active", {31'd0, bus.wb_active}, 32'd0);
            chk("fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
            chk("fetch_mem_address", bus.mem_address, {a[31:2], 2'b00});
            tick();
        end
        bus.mem_waitrequest = 1'b1;
        #1;
        chk("resp_state", {30'd0, bus.state_out}, 32'd3);
        chk("resp_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd0);
        chk("resp_wb_active", {31'd0, bus.wb_active}, 32'd1);
        tick();
        bus.cpu_read = 1'b0;
        #1;
        chk("back_to_idle", {30'd0, bus.state_out}, 32'd0);
    endtask

    task automatic read_miss(input logic [31:0] a, input logic [31:0] d, input int waits);
        bus.cpu_address = a;
        bus.cpu_read    = 1'b1;
        exp_rd.push_back(d);
        #1;
        chk("miss_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd1);
        tick();
        fetch_phase(a, d, waits);
    endtask

    task automatic read_hit(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_address = a;
        bus.cpu_read    = 1'b1;
        exp_rd.push_back(d);
        #1;
        chk("hit_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd0);
        chk("hit_state", {30'd0, bus.state_out}, 32'd0);
        tick();
        bus.cpu_read = 1'b0;
    endtask

    task automatic write_ok(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.cpu_address    = a;
        bus.cpu_writedata  = d;
        bus.cpu_byteenable = be;
        bus.cpu_write      = 1'b1;
        exp_wb.push_back('{addr: {a[31:2], 2'b00}, data: d, be: be});
        #1;
        chk("write_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd0);
        chk("write_push", {31'd0, bus.wb_write_en}, 32'd1);
        tick();
        bus.cpu_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        bus.cpu_address     = '0;
        bus.cpu_read        = 1'b0;
        bus.cpu_write       = 1'b0;
        bus.cpu_byteenable  = '0;
        bus.cpu_writedata   = '0;
        bus.wb_full         = 1'b0;
        bus.wb_empty        = 1'b1;
        bus.mem_waitrequest = 1'b1;
        bus.mem_readdata    = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_state", {30'd0, bus.state_out}, 32'd0);
        chk("rst_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd0);
        chk("rst_wb_write_en", {31'd0, bus.wb_write_en}, 32'd0);
        chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("rst_wb_active", {31'd0, bus.wb_active}, 32'd1);
        tick();

        // Miss with three memory wait cycles, then a zero-cycle hit
        read_miss(32'h0000_0040, 32'hDEAD_BEEF, 3);
        read_hit(32'h0000_0040, 32'hDEAD_BEEF);

        // Partial write hit merges into the line
        write_ok(32'h0000_0040, 32'h0000_1234, 4'b0011);
        read_hit(32'h0000_0040, 32'hDEAD_1234);

        // Read and write together behave as a write
        bus.cpu_read = 1'b1;
        write_ok(32'h0000_0042, 32'hBEEF_0000, 4'b1100);
        bus.cpu_read = 1'b0;
        read_hit(32'h0000_0040, 32'hBEEF_1234);

        // Write miss does not allocate; read waits in DRAIN for 5 cycles
        write_ok(32'h0000_0080, 32'h55AA_55AA, 4'b1111);
        bus.wb_empty    = 1'b0;
        bus.cpu_address = 32'h0000_0080;
        bus.cpu_read    = 1'b1;
        exp_rd.push_back(32'h1234_5678);
        #1;
        chk("wmiss_noalloc_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.wb_empty = (i == 4);
            #1;
            chk("drain_state", {30'd0, bus.state_out}, 32'd1);
            chk("drain_wb_active", {31'd0, bus.wb_active}, 32'd1);
            chk("drain_mem_read", {31'd0, bus.mem_read}, 32'd0);
            chk("drain_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd1);
            tick();
        end
        fetch_phase(32'h0000_0080, 32'h1234_5678, 0);

        // Write stalled by a full buffer for 3 cycles
        bus.wb_full        = 1'b1;
        bus.cpu_address    = 32'h0000_00C0;
        bus.cpu_writedata  = 32'hCAFE_F00D;
        bus.cpu_byteenable = 4'b1111;
        bus.cpu_write      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_waitreq", {31'd0, bus.cpu_waitrequest}, 32'd1);
            chk("full_no_push", {31'd0, bus.wb_write_en}, 32'd0);
            tick();
        end
        bus.wb_full = 1'b0;
        write_ok(32'h0000_00C0, 32'hCAFE_F00D, 4'b1111);

        // Index conflict: 0x00 and 0x40 share line 0
        read_miss(32'h0000_0000, 32'h0000_0011, 0);
        read_miss(32'h0000_0040, 32'h0000_0022, 1);
        read_miss(32'h0000_0000, 32'h0000_0033, 0);
        read_hit(32'h0000_0000, 32'h0000_0033);

        // Reset in the middle of a fetch abandons it and clears valid bits
        bus.cpu_address = 32'h0000_0104;
        bus.cpu_read    = 1'b1;
        tick();
        #1;
        chk("pre_rst_fetch", {30'd0, bus.state_out}, 32'd2);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.cpu_read = 1'b0;
        #1;
        chk("midrst_state", {30'd0, bus.state_out}, 32'd0);
        chk("midrst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("midrst_wb_active", {31'd0, bus.wb_active}, 32'd1);
        tick();
        read_miss(32'h0000_0000, 32'h0000_0044, 0);

        tick();
        tick();
        chk("rd_queue_empty", exp_rd.size(), 32'd0);
        chk("wb_queue_empty", exp_wb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
